// File: rtl/simple_rx_mcdma_s2mm.sv
// rtl/simple_rx_mcdma_s2mm.sv - multichannel stream-to-memory receive DMA with stall watchdog
//
// One AXI-Stream input carries packets for up to NUM_CH channels, selected
// by tdest on the first beat. Each channel holds one armed descriptor
// {base byte address, capacity in beats}. A packet is written beat-by-beat
// to that channel's buffer and then consumes the descriptor with one
// completion record.
//
// Ports:
//   clock, reset            single rising-edge clock, synchronous active-high reset
//   desc_valid/desc_ready   descriptor handshake; desc_ch/desc_addr/desc_len payload
//   s_axis_t*               packet stream input (tdest sampled on first beat only)
//   m_wr_valid/m_wr_ready   memory write request; m_wr_addr/m_wr_data payload
//   cmpl_valid/cmpl_ready   completion handshake; cmpl_ch/cmpl_beats/cmpl_ovf payload
//   block                   stall watchdog output to the deadlock-monitor tree
module simple_rx_mcdma_s2mm #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int LEN_W       = 16,
  parameter int STALL_LIMIT = 1024
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [CH_W-1:0]   desc_ch,
  input  logic [ADDR_W-1:0] desc_addr,
  input  logic [LEN_W-1:0]  desc_len,

  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  input  logic [CH_W-1:0]   s_axis_tdest,

  output logic              m_wr_valid,
  input  logic              m_wr_ready,
  output logic [ADDR_W-1:0] m_wr_addr,
  output logic [DATA_W-1:0] m_wr_data,

  output logic              cmpl_valid,
  input  logic              cmpl_ready,
  output logic [CH_W-1:0]   cmpl_ch,
  output logic [LEN_W-1:0]  cmpl_beats,
  output logic              cmpl_ovf,

  output logic              block
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_XFER  = 3'd1;
  localparam logic [2:0] ST_DROP  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_CMPL  = 3'd4;

  localparam int          BYTE_SH  = $clog2(DATA_W / 8);
  localparam int          CNT_W    = $clog2(STALL_LIMIT + 1);
  localparam logic [31:0] NUM_CH_U = NUM_CH;
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_LIMIT);

  // Channel ids beyond NUM_CH (possible when NUM_CH is not a power of two)
  // are never armed, so such packets stall and eventually trip the watchdog.
  function automatic logic ch_ok(input logic [CH_W-1:0] ch);
    return 32'(ch) < NUM_CH_U;
  endfunction

  // Descriptor table
  logic [NUM_CH-1:0] armed;
  logic [ADDR_W-1:0] addr_tab [NUM_CH];
  logic [LEN_W-1:0]  len_tab  [NUM_CH];

  // Packet engine state
  logic [2:0]        state;
  logic [CH_W-1:0]   cur_ch;
  logic [LEN_W-1:0]  beat_cnt;
  logic              ovf;

  // Watchdog
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  stall_cnt_next;
  logic              stall;

  logic              desc_fire;
  logic              cmpl_fire;
  logic              beat_fire;
  logic              wr_free;
  logic              tdest_armed;
  logic              room;
  logic [LEN_W-1:0]  cur_len;
  logic [ADDR_W-1:0] cur_base;
  logic [ADDR_W-1:0] beat_off;
  logic [ADDR_W-1:0] wr_addr_next;

  // Ready is held low while in reset so every output reads zero.
  assign desc_ready  = !reset && ch_ok(desc_ch) && !armed[desc_ch];
  assign desc_fire   = desc_valid && desc_ready;

  assign tdest_armed = ch_ok(s_axis_tdest) && armed[s_axis_tdest];
  assign cur_len     = len_tab[cur_ch];
  assign cur_base    = addr_tab[cur_ch];
  assign room        = beat_cnt < cur_len;

  // Byte offset of the current beat; the sum wraps modulo 2^ADDR_W.
  assign beat_off     = ADDR_W'(beat_cnt) << BYTE_SH;
  assign wr_addr_next = cur_base + beat_off;

  // The output register can take a new beat when empty or draining this cycle.
  assign wr_free = !m_wr_valid || m_wr_ready;

  always_comb begin
    s_axis_tready = 1'b0;
    case (state)
      ST_XFER: s_axis_tready = wr_free;
      ST_DROP: s_axis_tready = 1'b1;
      default: s_axis_tready = 1'b0;
    endcase
  end

  assign beat_fire  = s_axis_tvalid && s_axis_tready;

  assign cmpl_valid = (state == ST_CMPL);
  assign cmpl_ch    = cur_ch;
  assign cmpl_beats = beat_cnt;
  assign cmpl_ovf   = ovf;
  assign cmpl_fire  = cmpl_valid && cmpl_ready;

  // Descriptor payload needs no reset: it is only read while armed.
  always_ff @(posedge clock) begin
    if (desc_fire) begin
      addr_tab[desc_ch] <= desc_addr;
      len_tab[desc_ch]  <= desc_len;
    end
  end

  // A channel being completed is armed, so desc_ready is low for it in the
  // same cycle; set and clear can never collide on one channel.
  always_ff @(posedge clock) begin
    if (reset) begin
      armed <= '0;
    end else begin
      if (desc_fire) begin
        armed[desc_ch] <= 1'b1;
      end
      if (cmpl_fire) begin
        armed[cur_ch] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      cur_ch     <= '0;
      beat_cnt   <= '0;
      ovf        <= 1'b0;
      m_wr_valid <= 1'b0;
      m_wr_addr  <= '0;
      m_wr_data  <= '0;
    end else begin
      if (m_wr_valid && m_wr_ready) begin
        m_wr_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          // The first beat is only inspected here; XFER consumes it.
          if (s_axis_tvalid) begin
            cur_ch <= s_axis_tdest;
            if (tdest_armed) begin
              state    <= ST_XFER;
              beat_cnt <= '0;
              ovf      <= 1'b0;
            end
          end
        end

        ST_XFER: begin
          if (beat_fire) begin
            if (room) begin
              m_wr_valid <= 1'b1;
              m_wr_addr  <= wr_addr_next;
              m_wr_data  <= s_axis_tdata;
              beat_cnt   <= beat_cnt + 1'b1;
            end else begin
              ovf <= 1'b1;
            end
            if (s_axis_tlast) begin
              state <= ST_DRAIN;
            end else if (!room) begin
              state <= ST_DROP;
            end
          end
        end

        ST_DROP: begin
          if (beat_fire && s_axis_tlast) begin
            state <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (wr_free) begin
            state <= ST_CMPL;
          end
        end

        ST_CMPL: begin
          if (cmpl_ready) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign stall = (state == ST_IDLE && s_axis_tvalid && !tdest_armed)
              || (m_wr_valid && !m_wr_ready)
              || (cmpl_valid && !cmpl_ready);

  always_comb begin
    stall_cnt_next = '0;
    if (stall) begin
      stall_cnt_next = (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + 1'b1;
    end
  end

  // block tracks the counter's new value so it rises on the edge the
  // counter saturates and falls on the edge after the first non-stall cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
      block     <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_next;
      block     <= (stall_cnt_next == STALL_MAX);
    end
  end

endmodule

// File: tb/tb_simple_rx_mcdma_s2mm.sv
// tb/tb_simple_rx_mcdma_s2mm.sv - directed self-checking bench for simple_rx_mcdma_s2mm
module tb_simple_rx_mcdma_s2mm;

  logic        clock = 1'b0;
  logic        reset;
  logic        desc_valid;
  logic        desc_ready;
  logic [1:0]  desc_ch;
  logic [31:0] desc_addr;
  logic [15:0] desc_len;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [1:0]  s_axis_tdest;
  logic        m_wr_valid;
  logic        m_wr_ready;
  logic [31:0] m_wr_addr;
  logic [31:0] m_wr_data;
  logic        cmpl_valid;
  logic        cmpl_ready;
  logic [1:0]  cmpl_ch;
  logic [15:0] cmpl_beats;
  logic        cmpl_ovf;
  logic        block;

  always #5 clock = ~clock;

  simple_rx_mcdma_s2mm #(
    .DATA_W(32), .ADDR_W(32), .NUM_CH(4), .CH_W(2), .LEN_W(16), .STALL_LIMIT(8)
  ) dut (
    .clock(clock), .reset(reset),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_ch(desc_ch),
    .desc_addr(desc_addr), .desc_len(desc_len),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_axis_tdest(s_axis_tdest),
    .m_wr_valid(m_wr_valid), .m_wr_ready(m_wr_ready),
    .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data),
    .cmpl_valid(cmpl_valid), .cmpl_ready(cmpl_ready), .cmpl_ch(cmpl_ch),
    .cmpl_beats(cmpl_beats), .cmpl_ovf(cmpl_ovf),
    .block(block)
  );

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] beats;
    logic        ovf;
  } cmpl_t;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_cmpl_seen = 0;
  bit ignore_wr = 1'b0;
  bit wr_mode = 1'b0;

  // Scoreboard of expected traffic and log of observed traffic
  logic [31:0] ew_addr[$];
  logic [31:0] ew_data[$];
  cmpl_t       ec[$];
  logic [31:0] lw_addr[$];
  logic [31:0] lw_data[$];
  int          lw_cyc[$];
  cmpl_t       lc[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  task automatic flag(input string name);
    n_chk++;
    $display("FAIL %s: actual=occurred required=absent", name);
  endtask

  // Model: a packet of n beats into a buffer of len beats writes the first
  // min(n,len) beats at consecutive word addresses, then reports overflow
  // whenever the packet was longer than the buffer.
  task automatic expect_pkt(input logic [1:0] ch, input logic [31:0] a, input int len,
                            input int n, input logic [31:0] d0);
    int k;
    cmpl_t c;
    k = (n < len) ? n : len;
    for (int i = 0; i < k; i++) begin
      ew_addr.push_back(a + 32'(i) * 32'd4);
      ew_data.push_back(d0 + 32'(i));
    end
    c.ch = ch;
    c.beats = 16'(k);
    c.ovf = (n > len);
    ec.push_back(c);
  endtask

  // All tasks below start and end at posedge+1.
  task automatic arm(input logic [1:0] ch, input logic [31:0] a, input logic [15:0] l);
    bit got;
    got = 1'b0;
    desc_valid = 1'b1; desc_ch = ch; desc_addr = a; desc_len = l;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clock); got = desc_ready;
      @(posedge clock); #1;
    end
    desc_valid = 1'b0;
    if (!got) flag("desc_timeout");
  endtask

  // tdest is scrambled on non-first beats; the DUT must ignore it.
  task automatic send_pkt(input logic [1:0] ch, input int n, input logic [31:0] d0, input bit last);
    bit got;
    for (int i = 0; i < n; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdest  = (i == 0) ? ch : ~ch;
      s_axis_tdata  = d0 + 32'(i);
      s_axis_tlast  = last && (i == n - 1);
      got = 1'b0;
      for (int t = 0; t < 200 && !got; t++) begin
        @(negedge clock); got = s_axis_tready;
        @(posedge clock); #1;
      end
      if (!got) begin
        flag("beat_timeout");
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_cmpl(input int target);
    for (int t = 0; t < 300 && n_cmpl_seen < target; t++) @(negedge clock);
    if (n_cmpl_seen < target) flag("cmpl_timeout");
    @(posedge clock); #1;
  endtask

  // Write-ready pattern: steady high, or toggling every cycle
  initial begin
    m_wr_ready = 1'b1;
    forever begin
      @(posedge clock); #1;
      if (wr_mode) m_wr_ready = ~m_wr_ready;
      else m_wr_ready = 1'b1;
    end
  end

  // Compare process: every handshake against the scoreboard, every stalled
  // request against its previous-cycle value.
  initial begin
    logic pw_v, pw_r, pc_v, pc_r;
    logic [31:0] pw_a, pw_d;
    cmpl_t pc, e, got_c;
    pw_v = 0; pw_r = 0; pc_v = 0; pc_r = 0; pw_a = 0; pw_d = 0; pc = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        pw_v = 0; pc_v = 0;
      end else begin
        if (pw_v && !pw_r) begin
          check("wr_hold_valid", 64'(m_wr_valid), 64'd1);
          check("wr_hold_bits", {m_wr_addr, m_wr_data}, {pw_a, pw_d});
        end
        got_c.ch = cmpl_ch; got_c.beats = cmpl_beats; got_c.ovf = cmpl_ovf;
        if (pc_v && !pc_r) begin
          check("cmpl_hold_valid", 64'(cmpl_valid), 64'd1);
          check("cmpl_hold_bits", 64'(got_c), 64'(pc));
        end
        if (m_wr_valid && m_wr_ready && !ignore_wr) begin
          if (ew_addr.size() == 0) flag("wr_unexpected");
          else begin
            check("wr_addr", 64'(m_wr_addr), 64'(ew_addr.pop_front()));
            check("wr_data", 64'(m_wr_data), 64'(ew_data.pop_front()));
          end
          lw_addr.push_back(m_wr_addr);
          lw_data.push_back(m_wr_data);
          lw_cyc.push_back(cyc);
        end
        if (cmpl_valid && cmpl_ready) begin
          if (ec.size() == 0) flag("cmpl_unexpected");
          else begin
            e = ec.pop_front();
            check("cmpl_ch", 64'(cmpl_ch), 64'(e.ch));
            check("cmpl_beats", 64'(cmpl_beats), 64'(e.beats));
            check("cmpl_ovf", 64'(cmpl_ovf), 64'(e.ovf));
          end
          lc.push_back(got_c);
          n_cmpl_seen++;
        end
        pw_v = m_wr_valid; pw_r = m_wr_ready; pw_a = m_wr_addr; pw_d = m_wr_data;
        pc_v = cmpl_valid; pc_r = cmpl_ready; pc = got_c;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    desc_valid = 0; desc_ch = 0; desc_addr = 0; desc_len = 0;
    s_axis_tdata = 0; s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tdest = 0;
    cmpl_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_tready", 64'(s_axis_tready), 64'd0);
    check("rst_wr_valid", 64'(m_wr_valid), 64'd0);
    check("rst_wr_bits", {m_wr_addr, m_wr_data}, 64'd0);
    check("rst_cmpl", {cmpl_valid, cmpl_ch, cmpl_beats, cmpl_ovf}, 64'd0);
    check("rst_block", 64'(block), 64'd0);
    check("rst_desc_ready", 64'(desc_ready), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("idle_desc_ready", 64'(desc_ready), 64'd1);
    @(posedge clock); #1;

    // Exact-fit packet, back-to-back writes
    arm(2'd1, 32'h1000, 16'd4);
    expect_pkt(2'd1, 32'h1000, 4, 4, 32'hA0);
    send_pkt(2'd1, 4, 32'hA0, 1'b1);
    wait_cmpl(1);
    check("t1_nwr", 64'(lw_addr.size()), 64'd4);
    check("t1_wr0", {lw_addr[0], lw_data[0]}, {32'h1000, 32'hA0});
    check("t1_wr3", {lw_addr[3], lw_data[3]}, {32'h100C, 32'hA3});
    check("t1_back_to_back", 64'(lw_cyc[3] - lw_cyc[0]), 64'd3);
    check("t1_cmpl", 64'(lc[0]), 64'({2'd1, 16'd4, 1'b0}));
    desc_ch = 2'd1;
    @(negedge clock);
    check("t1_rearm_ready", 64'(desc_ready), 64'd1);
    @(posedge clock); #1;

    // Overflow: 5 beats into a 2-beat buffer
    arm(2'd2, 32'h2000, 16'd2);
    expect_pkt(2'd2, 32'h2000, 2, 5, 32'hB0);
    send_pkt(2'd2, 5, 32'hB0, 1'b1);
    wait_cmpl(2);
    check("t2_nwr", 64'(lw_addr.size()), 64'd6);
    check("t2_wr_last", {lw_addr[5], lw_data[5]}, {32'h2004, 32'hB1});
    check("t2_cmpl", 64'(lc[1]), 64'({2'd2, 16'd2, 1'b1}));

    // Unarmed channel stalls and trips the watchdog after 8 cycles
    expect_pkt(2'd3, 32'h3000, 3, 3, 32'h30);
    fork
      send_pkt(2'd3, 3, 32'h30, 1'b1);
      begin
        repeat (7) @(posedge clock);
        @(negedge clock);
        check("t3_block_7", 64'(block), 64'd0);
        check("t3_tready", 64'(s_axis_tready), 64'd0);
        @(posedge clock);
        @(negedge clock);
        check("t3_block_8", 64'(block), 64'd1);
        check("t3_tready_8", 64'(s_axis_tready), 64'd0);
        @(posedge clock); #1;
        arm(2'd3, 32'h3000, 16'd3);
        @(negedge clock);
        check("t3_block_held", 64'(block), 64'd1);
        @(negedge clock);
        check("t3_block_clear", 64'(block), 64'd0);
      end
    join
    wait_cmpl(3);
    check("t3_cmpl", 64'(lc[2]), 64'({2'd3, 16'd3, 1'b0}));

    // Write-ready toggling every cycle
    wr_mode = 1'b1;
    arm(2'd0, 32'h4000, 16'd8);
    expect_pkt(2'd0, 32'h4000, 8, 6, 32'h40);
    send_pkt(2'd0, 6, 32'h40, 1'b1);
    wait_cmpl(4);
    wr_mode = 1'b0;
    check("t4_cmpl", 64'(lc[3]), 64'({2'd0, 16'd6, 1'b0}));

    // Completion back-pressure with a new packet and re-arm waiting
    cmpl_ready = 1'b0;
    arm(2'd0, 32'h5000, 16'd4);
    expect_pkt(2'd0, 32'h5000, 4, 2, 32'h50);
    send_pkt(2'd0, 2, 32'h50, 1'b1);
    for (int t = 0; t < 100 && !cmpl_valid; t++) @(negedge clock);
    @(posedge clock); #1;
    s_axis_tvalid = 1'b1; s_axis_tdest = 2'd0; s_axis_tdata = 32'h60; s_axis_tlast = 1'b0;
    desc_valid = 1'b1; desc_ch = 2'd0; desc_addr = 32'h6000; desc_len = 16'd4;
    repeat (5) begin
      @(negedge clock);
      check("t5_tready", 64'(s_axis_tready), 64'd0);
      check("t5_desc_rej", 64'(desc_ready), 64'd0);
      check("t5_cmpl", {cmpl_valid, cmpl_ch, cmpl_beats, cmpl_ovf}, 64'({1'b1, 2'd0, 16'd2, 1'b0}));
      @(posedge clock); #1;
    end
    cmpl_ready = 1'b1;
    @(negedge clock);
    check("t5_desc_same_cycle", 64'(desc_ready), 64'd0);
    @(posedge clock); #1;
    @(negedge clock);
    check("t5_desc_next_cycle", 64'(desc_ready), 64'd1);
    @(posedge clock); #1;
    desc_valid = 1'b0;
    expect_pkt(2'd0, 32'h6000, 4, 3, 32'h60);
    send_pkt(2'd0, 3, 32'h60, 1'b1);
    wait_cmpl(6);
    check("t5_cmpl2", 64'(lc[5]), 64'({2'd0, 16'd3, 1'b0}));

    // Reset in the middle of a packet
    arm(2'd1, 32'h7000, 16'd4);
    ignore_wr = 1'b1;
    send_pkt(2'd1, 2, 32'h70, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("t6_tready", 64'(s_axis_tready), 64'd0);
    check("t6_wr_valid", 64'(m_wr_valid), 64'd0);
    check("t6_wr_bits", {m_wr_addr, m_wr_data}, 64'd0);
    check("t6_cmpl", {cmpl_valid, cmpl_ch, cmpl_beats, cmpl_ovf}, 64'd0);
    check("t6_block", 64'(block), 64'd0);
    check("t6_desc_ready", 64'(desc_ready), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    ignore_wr = 1'b0;
    desc_ch = 2'd1;
    repeat (10) @(negedge clock);
    check("t6_disarmed", 64'(desc_ready), 64'd1);
    check("t6_no_cmpl", 64'(n_cmpl_seen), 64'd6);
    @(posedge clock); #1;
    arm(2'd1, 32'h8000, 16'd4);
    expect_pkt(2'd1, 32'h8000, 4, 4, 32'h80);
    send_pkt(2'd1, 4, 32'h80, 1'b1);
    wait_cmpl(7);
    check("t6_cmpl_after", 64'(lc[6]), 64'({2'd1, 16'd4, 1'b0}));

    check("sb_wr_left", 64'(ew_addr.size()), 64'd0);
    check("sb_cmpl_left", 64'(ec.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/simple_rx_mcdma_s2mm.md
Name: simple_rx_mcdma_s2mm

Overview:
- Receive-direction counterpart of the Tx multichannel DMA: accepts one AXI-Stream input carrying packets for up to NUM_CH channels (selected by TDEST) and writes each packet beat-by-beat to the memory buffer armed for that channel.
- Per channel: one armed descriptor (base address, length in beats). Each packet consumes it and produces one completion record.
- Includes a stall watchdog whose `block` output feeds the design's deadlock-monitor tree.

Parameters:
- DATA_W, 32, stream/write data width in bits (power of two, ≥8)
- ADDR_W, 32, byte address width
- NUM_CH, 4, number of channels
- CH_W, 2, channel id width (clog2 NUM_CH, ≥1)
- LEN_W, 16, descriptor length / beat counter width
- STALL_LIMIT, 1024, consecutive stalled cycles before `block` asserts

Ports:
- clock  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- desc_valid  in  1  descriptor offered
- desc_ready  out  1  descriptor accepted when high with desc_valid
- desc_ch  in  CH_W  target channel
- desc_addr  in  ADDR_W  buffer base byte address
- desc_len  in  LEN_W  buffer capacity in beats
- s_axis_tdata  in  DATA_W  stream data
- s_axis_tvalid  in  1  stream valid
- s_axis_tready  out  1  stream ready
- s_axis_tlast  in  1  last beat of packet
- s_axis_tdest  in  CH_W  channel of packet (sampled on first beat only)
- m_wr_valid  out  1  write request valid
- m_wr_ready  in  1  write request accepted
- m_wr_addr  out  ADDR_W  write byte address
- m_wr_data  out  DATA_W  write data
- cmpl_valid  out  1  completion record valid
- cmpl_ready  in  1  completion accepted
- cmpl_ch  out  CH_W  completed channel
- cmpl_beats  out  LEN_W  beats written to memory
- cmpl_ovf  out  1  packet exceeded buffer; excess beats dropped
- block  out  1  stall watchdog tripped

Behaviour:
- Reset: every output low or zero; all armed bits cleared; FSM in IDLE; stall counter 0. A reset mid-packet abandons the packet: no completion is issued and no further writes are made.
- Descriptor table: per channel {armed, addr, len}.
  - desc_ready = !armed[desc_ch], using the registered armed bit.
  - On handshake: store addr and len, set armed next cycle.
  - If a completion clears a channel's armed bit in cycle N, a re-arm of that channel is accepted no earlier than cycle N+1.
- FSM states: IDLE, XFER, DROP, DRAIN, CMPL.
  - IDLE: s_axis_tready=0. When tvalid is high, latch tdest into cur_ch. If armed[tdest], go to XFER with beat_cnt=0 and ovf=0; the beat itself is not consumed in IDLE. If not armed, stay in IDLE (stall).
  - XFER: s_axis_tready = !m_wr_valid | m_wr_ready (one-entry output register, 1-cycle latency stream→write). On accepting a beat with beat_cnt < len:
    - load m_wr_data = tdata
    - load m_wr_addr = addr + beat_cnt·(DATA_W/8), modulo 2^ADDR_W, wraps silently
    - beat_cnt++
  - XFER, buffer full: if beat_cnt == len (including len=0), the beat is not written; set ovf=1. If it is not tlast, go to DROP.
  - XFER, tlast accepted: go to DRAIN.
  - DROP: s_axis_tready=1. Discard beats until tlast is accepted, then go to DRAIN.
  - DRAIN: wait until m_wr_valid is low or m_wr_ready is high, i.e. the last write has been accepted. Then go to CMPL.
  - CMPL: cmpl_valid=1 with cmpl_ch=cur_ch, cmpl_beats=beat_cnt, cmpl_ovf=ovf. Fields are held stable until cmpl_ready. On handshake: clear armed[cur_ch] and return to IDLE. No new packet is accepted in CMPL.
- m_wr_valid, once high, stays high with stable addr and data until m_wr_ready.
- tdest on non-first beats is ignored.
- Stall watchdog:
  - Stall cycle: (IDLE & tvalid & !armed[tdest]) | (m_wr_valid & !m_wr_ready) | (cmpl_valid & !cmpl_ready).
  - Counter increments on stall cycles, saturates at STALL_LIMIT, and clears to 0 on any non-stall cycle.
  - block is a register: 1 when the counter equals STALL_LIMIT, otherwise 0. It deasserts the cycle after the stall condition ends.
- Throughput: one beat per cycle in XFER with m_wr_ready held high. Per-packet overhead: 1 IDLE cycle + DRAIN + 1 CMPL cycle minimum.

Test Plan:
- Arm ch1 (addr 0x1000, len 4), send 4-beat packet tdest=1 (data 0xA0..0xA3), m_wr_ready=1 → writes 0x1000/0xA0, 0x1004/0xA1, 0x1008/0xA2, 0x100C/0xA3 on consecutive cycles; cmpl ch=1, beats=4, ovf=0; desc_ready for ch1 high again after the handshake.
- Arm ch2 (len 2), send 5-beat packet tdest=2 → exactly 2 writes, remaining 3 beats accepted and dropped, cmpl beats=2 ovf=1.
- Packet tdest=3 with ch3 unarmed, STALL_LIMIT=8 → s_axis_tready=0, block=1 after 8 stalled cycles; arm ch3 → block=0 on the next cycle, packet proceeds normally.
- m_wr_ready toggling 1/0 every cycle during 6-beat packet → no beat lost or duplicated, addr/data stable while m_wr_ready=0, cmpl beats=6.
- cmpl_ready held low 5 cycles, then a second packet arrives for ch0 → cmpl fields stable, stream not accepted until the handshake; desc for the same channel rejected while armed.
- Reset asserted mid-packet (after beat 2 of 4) → all outputs 0 next cycle, armed bits cleared, no completion; new descriptor plus packet afterwards completes normally.
